// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory controller.
// Contents: FSM state encoding (IDLE/LOAD/FLUSH) and the NOP word returned on
// misaligned fetches. Optional parity column is enabled by IMEM_PARITY_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } imem_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: word-addressed RAM, one write port, one registered read port.
// Ports: clk/rst_n, i_we/i_waddr/i_wdata (write), i_re/i_raddr (read request),
//   o_rdata (read word, valid the cycle after i_re, holds otherwise),
//   o_perr (recomputed-parity mismatch, only when IMEM_PARITY_EN is defined).
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
`ifdef IMEM_PARITY_EN
  ,
  output logic                     o_perr
`endif
);

  // Storage array is deliberately not reset: contents survive rst_n.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Output register is reset so the response bus starts at zero, and only
  // loads on a read so the last response is held between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

`ifdef IMEM_PARITY_EN
  // Even parity: stored bit makes the XOR of data plus parity equal zero.
  logic r_par [DEPTH];
  logic r_perr;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_par[i_waddr] <= ^i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (i_re) begin
      r_perr <= (^r_mem[i_raddr]) ^ r_par[i_raddr];
    end
  end

  assign o_perr = r_perr;
`endif

endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with streaming boot-load port and 1-cycle fetch.
// Ports: clk/rst_n; load_start/load_base/load_count + load_valid/load_ready/load_data
//   handshake, load_done/busy status; fetch_req/fetch_addr/fetch_gnt request and
//   rsp_valid/rsp_data/rsp_err response; parity_err only when IMEM_PARITY_EN is defined.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-2:0] load_count,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_done,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2**(ADDR_W-2);
  localparam int WA    = ADDR_W - 2;
  localparam logic [ADDR_W-2:0] CNT_ONE = 1;

  imem_state_t         r_state;
  imem_state_t         w_state_nxt;
  logic [WA-1:0]       r_wptr;
  logic [ADDR_W-2:0]   r_remaining;
  logic                r_rsp_valid;
  logic                r_nop_sel;
  logic                w_load_hs;
  logic                w_fetch_acc;
  logic                w_misalign;
  logic [DATA_W-1:0]   w_ram_rdata;
  logic                w_unused_base;

  // Word granularity only: the byte offset of the load base is dropped.
  assign w_unused_base = ^load_base[1:0];

  assign w_load_hs   = load_valid & load_ready;
  assign w_fetch_acc = fetch_req & fetch_gnt;
  assign w_misalign  = (fetch_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    busy        = 1'b0;
    fetch_gnt   = 1'b0;
    case (r_state)
      IDLE: begin
        fetch_gnt = 1'b1;
        if (load_start) begin
          w_state_nxt = (load_count == '0) ? FLUSH : LOAD;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid && (r_remaining == CNT_ONE)) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        load_done   = 1'b1;
        busy        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Write pointer wraps naturally at DEPTH because it is exactly WA bits wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_remaining <= '0;
    end else if ((r_state == IDLE) && load_start) begin
      r_wptr      <= load_base[ADDR_W-1:2];
      r_remaining <= load_count;
    end else if (w_load_hs) begin
      r_wptr      <= r_wptr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  // r_nop_sel only changes on a granted fetch so rsp_data holds between
  // responses, whether the last one came from the RAM or was the NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_nop_sel   <= 1'b0;
    end else begin
      r_rsp_valid <= w_fetch_acc;
      if (w_fetch_acc) begin
        r_nop_sel <= w_misalign;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic w_ram_perr;
`endif

  // Fetches are granted only in IDLE and writes happen only in LOAD, so the
  // two ports never touch the array in the same cycle.
  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_load_hs),
    .i_waddr (r_wptr),
    .i_wdata (load_data),
    .i_re    (w_fetch_acc & ~w_misalign),
    .i_raddr (fetch_addr[ADDR_W-1:2]),
    .o_rdata (w_ram_rdata)
`ifdef IMEM_PARITY_EN
    ,
    .o_perr  (w_ram_perr)
`endif
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_valid & r_nop_sel;
  assign rsp_data  = r_nop_sel ? DATA_W'(IMEM_NOP) : w_ram_rdata;

`ifdef IMEM_PARITY_EN
  assign parity_err = r_rsp_valid & ~r_nop_sel & w_ram_perr;
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed + randomized bench for instr_mem_ctrl.
// Keeps a word-array model of memory contents and checks load handshake,
// fetch responses, misalignment, wrap-around, fetch blocking and mid-load reset.
module tb_instr_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic [ADDR_W-2:0] load_count = '0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_done;
  logic              busy;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_gnt;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
`ifdef IMEM_PARITY_EN
  logic              parity_err;
`endif

  instr_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_count (load_count),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_done  (load_done),
    .busy       (busy),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain word array indexed by word address.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] wq [$];
  logic [9:0]  fq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one load of wq at 'base' with random valid gaps; optionally issues a
  // fetch together with load_start and holds it for the whole load.
  task automatic do_load(input logic [9:0] base, input int count,
                         input bit with_fetch, input logic [9:0] faddr);
    int idx;
    int cyc;
    int wbase;
    bit v;
    logic [31:0] fexp;
    wbase = int'(base[9:2]);
    fexp  = model_mem[faddr[9:2]];
    load_start = 1'b1;
    load_base  = base;
    load_count = count[8:0];
    if (with_fetch) begin
      fetch_req  = 1'b1;
      fetch_addr = faddr;
      check("gnt_with_start", {31'b0, fetch_gnt}, 32'd1);
    end
    step();
    load_start = 1'b0;
    if (with_fetch) begin
      check("rsp_vld_first_load", {31'b0, rsp_valid}, 32'd1);
      check("rsp_dat_first_load", rsp_data, fexp);
    end
    check("busy_after_start", {31'b0, busy}, 32'd1);
    if (count == 0) begin
      check("done_zero_count", {31'b0, load_done}, 32'd1);
    end else begin
      check("rdy_after_start", {31'b0, load_ready}, 32'd1);
      idx = 0;
      cyc = 0;
      while (idx < count && cyc < count * 8 + 16) begin
        v = ($urandom_range(0, 3) != 0);
        load_valid = v;
        load_data  = wq[idx];
        step();
        cyc++;
        if (v) begin
          model_mem[(wbase + idx) % DEPTH] = wq[idx];
          idx++;
        end
        check("done_pulse", {31'b0, load_done}, {31'b0, (v && idx == count)});
        check("gnt_in_load", {31'b0, fetch_gnt}, 32'd0);
        check("rsp_vld_in_load", {31'b0, rsp_valid}, 32'd0);
      end
      load_valid = 1'b0;
      check("load_words_accepted", idx, count);
    end
    step();
    check("done_clear", {31'b0, load_done}, 32'd0);
    check("busy_clear", {31'b0, busy}, 32'd0);
    check("gnt_after_done", {31'b0, fetch_gnt}, 32'd1);
    if (with_fetch) begin
      check("rsp_vld_idle_first", {31'b0, rsp_valid}, 32'd0);
      step();
      fetch_req = 1'b0;
      check("rsp_vld_after_load", {31'b0, rsp_valid}, 32'd1);
      check("rsp_dat_after_load", rsp_data, model_mem[faddr[9:2]]);
    end
  endtask

  // Back-to-back fetches of every address in fq, then one idle cycle.
  task automatic fetch_seq();
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] last_d;
    logic [9:0]  a;
    last_d = '0;
    foreach (fq[i]) begin
      a = fq[i];
      fetch_req  = 1'b1;
      fetch_addr = a;
      check("fetch_gnt", {31'b0, fetch_gnt}, 32'd1);
      exp_e = (a[1:0] != 2'b00);
      exp_d = exp_e ? 32'h0000_0013 : model_mem[a[9:2]];
      step();
      check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_e});
      check("rsp_data", rsp_data, exp_d);
`ifdef IMEM_PARITY_EN
      check("parity_clean", {31'b0, parity_err}, 32'd0);
`endif
      last_d = exp_d;
    end
    fetch_req = 1'b0;
    step();
    check("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
    check("rsp_err_idle", {31'b0, rsp_err}, 32'd0);
    check("rsp_data_hold", rsp_data, last_d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  rbase;
    int          rcnt;
    logic [31:0] wa;
    logic [31:0] wb;

    // Reset state.
    #12;
    check("rst_load_ready", {31'b0, load_ready}, 32'd0);
    check("rst_load_done", {31'b0, load_done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_fetch_gnt", {31'b0, fetch_gnt}, 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // 17-word program at base 0, then fetch 0x000..0x040 back to back.
    wq.delete();
    wq.push_back(32'h0100_00df);
    for (int i = 0; i < 15; i++) wq.push_back($urandom);
    wq.push_back(32'h0000_8067);
    do_load(10'h000, 17, 1'b0, 10'h000);
    fq.delete();
    for (int i = 0; i < 17; i++) fq.push_back(10'(i * 4));
    fetch_seq();

    // Misaligned fetch returns NOP with rsp_err.
    fq.delete();
    fq.push_back(10'h006);
    fetch_seq();

    // Zero-count load goes straight to FLUSH.
    wq.delete();
    do_load(10'h040, 0, 1'b0, 10'h000);

    // Wrap-around: two words at 0x3FC land at words 255 and 0.
    wa = $urandom;
    wb = $urandom;
    wq.delete();
    wq.push_back(wa);
    wq.push_back(wb);
    do_load(10'h3FC, 2, 1'b0, 10'h000);
    fq.delete();
    fq.push_back(10'h3FC);
    fq.push_back(10'h000);
    fetch_seq();
    check("wrap_word0_is_B", model_mem[0], wb);

    // Fetch held through a 4-word load overwriting the fetched word.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    do_load(10'h010, 4, 1'b1, 10'h014);

    // Reset after 2 of 5 words.
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back($urandom);
    load_start = 1'b1;
    load_base  = 10'h100;
    load_count = 9'd5;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      load_valid = 1'b1;
      load_data  = wq[k];
      step();
      model_mem[64 + k] = wq[k];
    end
    load_valid = 1'b0;
    check("busy_before_rst", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ready", {31'b0, load_ready}, 32'd0);
    check("midrst_done", {31'b0, load_done}, 32'd0);
    check("midrst_gnt", {31'b0, fetch_gnt}, 32'd1);
    check("midrst_rsp_data", rsp_data, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("no_done_after_rst", {31'b0, load_done}, 32'd0);
    end
    fq.delete();
    fq.push_back(10'h100);
    fq.push_back(10'h104);
    fetch_seq();

    // Randomized loads at random bases (low base bits random too) with
    // random aligned / misaligned fetches inside the loaded region.
    for (int r = 0; r < 6; r++) begin
      rbase = 10'($urandom_range(0, 1023));
      rcnt  = $urandom_range(1, 12);
      wq.delete();
      for (int i = 0; i < rcnt; i++) wq.push_back($urandom);
      do_load(rbase, rcnt, 1'b0, 10'h000);
      fq.delete();
      for (int i = 0; i < 8; i++) begin
        fq.push_back(10'(((int'(rbase[9:2]) + $urandom_range(0, rcnt - 1)) % DEPTH) * 4
                         + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0)));
      end
      fetch_seq();
    end

`ifdef IMEM_PARITY_EN
    // Corrupt one stored bit behind the parity column's back.
    dut.u_ram.r_mem[5] = dut.u_ram.r_mem[5] ^ 32'h0000_0100;
    fetch_req  = 1'b1;
    fetch_addr = 10'h014;
    step();
    fetch_req = 1'b0;
    check("perr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("perr_flagged", {31'b0, parity_err}, 32'd1);
    fetch_req  = 1'b1;
    fetch_addr = 10'h018;
    step();
    fetch_req = 1'b0;
    check("perr_clean", {31'b0, parity_err}, 32'd0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
